// File: rtl/pico_fetch.sv
// pico_fetch: program counter and instruction fetch unit for the pico core.
// One request/valid fetch per instruction, one EXEC cycle, then a PC update chosen by the decoder.
module pico_fetch #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 16,
   parameter int OFF_W   = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   output logic               imem_req_o,
   output logic [PC_W-1:0]    imem_addr_o,
   input  logic               imem_rvalid_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic [INSTR_W-1:0] instr_o,
   output logic [4:0]         op_code_o,
   output logic               instr_valid_o,
   input  logic [1:0]         mode_pc_i,
   input  logic               halt_core_i,
   output logic [PC_W-1:0]    pc_o,
   output logic               halted_o,
   output logic [CNT_W-1:0]   retired_o
);

   localparam logic [1:0] MODE_INCREMENT = 2'd0;
   localparam logic [1:0] MODE_RELATIVE  = 2'd1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED} state_t;

   state_t                   r_state, w_state_nxt;
   logic [PC_W-1:0]          r_pc, w_pc_nxt;
   logic [INSTR_W-1:0]       r_instr, w_instr_nxt;
   logic [CNT_W-1:0]         r_retired, w_retired_nxt;
   logic                     r_req, r_valid, r_halted;
   logic signed [OFF_W-1:0]  w_off;
   logic                     w_stop;

   assign w_off  = $signed(r_instr[OFF_W-1:0]);
   // HALTCOUNT and the reserved mode both stop the core, as does an explicit halt request.
   assign w_stop = halt_core_i || ((mode_pc_i != MODE_INCREMENT) && (mode_pc_i != MODE_RELATIVE));

   always_comb begin
      // NOTE: every next-value gets its default first, so no path through the case infers a latch.
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_instr_nxt   = r_instr;
      w_retired_nxt = r_retired;
      case (r_state)
         S_IDLE: begin
            if (start_i) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (imem_rvalid_i) begin
               w_instr_nxt = imem_rdata_i;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_stop) begin
               w_state_nxt = S_HALTED;
            end else begin
               w_state_nxt = S_FETCH;
               if (mode_pc_i == MODE_RELATIVE) w_pc_nxt = r_pc + PC_W'(w_off);
               else                            w_pc_nxt = r_pc + PC_W'(1);
               if (r_retired != '1) w_retired_nxt = r_retired + CNT_W'(1);
            end
         end
         S_HALTED: begin
            w_state_nxt = S_HALTED;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= S_IDLE;
         r_pc      <= '0;
         r_instr   <= '0;
         r_retired <= '0;
         r_req     <= 1'b0;
         r_valid   <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         // NOTE: non-blocking, so every register samples the values from before this edge.
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_instr   <= w_instr_nxt;
         r_retired <= w_retired_nxt;
         r_req     <= (w_state_nxt == S_FETCH);
         r_valid   <= (w_state_nxt == S_EXEC);
         r_halted  <= (w_state_nxt == S_HALTED);
      end
   end

   assign imem_req_o    = r_req;
   assign imem_addr_o   = r_pc;
   assign instr_o       = r_instr;
   assign op_code_o     = r_instr[INSTR_W-1 -: 5];
   assign instr_valid_o = r_valid;
   assign pc_o          = r_pc;
   assign halted_o      = r_halted;
   assign retired_o     = r_retired;

endmodule

// File: tb/tb_pico_fetch.sv
// Directed bench for pico_fetch: memory with programmable wait states, a small decoder model,
// and a second instance with a 2-bit retire counter for saturation.
module tb_pico_fetch;

   localparam logic [4:0] OP_ADD    = 5'h01;
   localparam logic [4:0] OP_BEQ    = 5'h02;
   localparam logic [4:0] OP_HLTREQ = 5'h03;
   localparam logic [4:0] OP_RSVD   = 5'h04;
   localparam logic [4:0] OP_UNDEF  = 5'h1E;
   localparam logic [4:0] OP_HALT   = 5'h1F;

   logic        clk = 1'b0;
   logic        rst_n, start, force_rv, rvalid;
   logic        req, valid, halted, halt_req;
   logic [7:0]  addr, pc;
   logic [15:0] rdata, instr, retired;
   logic [4:0]  op;
   logic [1:0]  mode, beq_mode;
   logic [15:0] mem [256];
   int          wait_n, wcnt;

   logic        rst2_n, start2, req2, valid2, halted2;
   logic [7:0]  addr2, pc2;
   logic [15:0] instr2;
   logic [4:0]  op2;
   logic [1:0]  retired2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pico_fetch dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start),
      .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .instr_o(instr), .op_code_o(op), .instr_valid_o(valid),
      .mode_pc_i(mode), .halt_core_i(halt_req),
      .pc_o(pc), .halted_o(halted), .retired_o(retired)
   );

   pico_fetch #(.CNT_W(2)) dut_sat (
      .clk_i(clk), .rst_ni(rst2_n), .start_i(start2),
      .imem_req_o(req2), .imem_addr_o(addr2), .imem_rvalid_i(1'b1), .imem_rdata_i(16'h0800),
      .instr_o(instr2), .op_code_o(op2), .instr_valid_o(valid2),
      .mode_pc_i(2'b00), .halt_core_i(1'b0),
      .pc_o(pc2), .halted_o(halted2), .retired_o(retired2)
   );

   // Memory: answers after wait_n request cycles; force_rv injects a response at any time.
   assign rvalid = force_rv | (req && (wcnt >= wait_n));
   assign rdata  = mem[addr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               wcnt <= 0;
      else if (req && !rvalid)  wcnt <= wcnt + 1;
      else                      wcnt <= 0;
   end

   always_comb begin
      mode     = 2'd0;
      halt_req = 1'b0;
      case (op)
         OP_ADD:    mode = 2'd0;
         OP_BEQ:    mode = beq_mode;
         OP_HLTREQ: halt_req = 1'b1;
         OP_RSVD:   mode = 2'd3;
         OP_HALT:   mode = 2'd2;
         default: begin
            mode     = 2'd2;
            halt_req = 1'b1;
         end
      endcase
   end

   function automatic logic [15:0] mk(input logic [4:0] o, input logic [7:0] off);
      return {o, 3'b000, off};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; start = 1'b0; force_rv = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic load_fill();
      for (int i = 0; i < 256; i++) mem[i] = mk(OP_HALT, 8'h00);
   endtask

   task automatic wait_exec_at(input logic [7:0] target, input string tag);
      int n = 0;
      while (!(valid && pc == target) && n < 300) begin
         cyc(1);
         n++;
      end
      check({tag, "_reached"}, 32'(valid && pc == target), 32'd1);
   endtask

   task automatic wait_halted(input string tag);
      int n = 0;
      while (!halted && n < 300) begin
         cyc(1);
         n++;
      end
      check({tag, "_halted"}, 32'(halted), 32'd1);
   endtask

   logic [10:0] exp1 [7];
   logic [7:0]  exp_br [2];
   logic [4:0]  stop_ops [2];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      exp1 = '{ {1'b1,1'b0,1'b0,8'd0}, {1'b0,1'b1,1'b0,8'd0}, {1'b1,1'b0,1'b0,8'd1},
                {1'b0,1'b1,1'b0,8'd1}, {1'b1,1'b0,1'b0,8'd2}, {1'b0,1'b1,1'b0,8'd2},
                {1'b0,1'b0,1'b1,8'd2} };
      exp_br   = '{8'd6, 8'd2};
      stop_ops = '{OP_HLTREQ, OP_RSVD};
      wait_n = 0; beq_mode = 2'd0;
      rst2_n = 1'b0; start2 = 1'b0;
      load_fill();

      // Saturating retire counter on the 2-bit instance (ADD forever, zero wait).
      cyc(2);
      rst2_n = 1'b1;
      cyc(1);
      check("sat_reset", 32'(retired2), 32'd0);
      start2 = 1'b1; cyc(1); start2 = 1'b0;
      cyc(1); check("sat_exec1", 32'({valid2, retired2}), {29'd0, 1'b1, 2'd0});
      cyc(1); check("sat_ret1", 32'(retired2), 32'd1);
      cyc(2); check("sat_ret2", 32'(retired2), 32'd2);
      cyc(2); check("sat_ret3", 32'(retired2), 32'd3);
      cyc(2); check("sat_hold", 32'(retired2), 32'd3);
      cyc(20); check("sat_hold_long", 32'({halted2, retired2}), 32'd3);

      // Program ADD, ADD, HALT with zero-wait memory.
      mem[0] = mk(OP_ADD, 8'h00); mem[1] = mk(OP_ADD, 8'h00); mem[2] = mk(OP_HALT, 8'h00);
      apply_reset();
      check("rst_state", {req, valid, halted, pc, instr}, 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      pulse_start();
      for (int k = 0; k < 7; k++) begin
         check($sformatf("prog_cyc%0d", k), 32'({req, valid, halted, pc}), 32'(exp1[k]));
         if (req) check($sformatf("prog_addr%0d", k), 32'(addr), 32'(pc));
         cyc(1);
      end
      check("prog_retired", 32'(retired), 32'd2);
      check("prog_final", {req, valid, halted, pc, instr}, {13'd0, 1'b1, 8'd2, mk(OP_HALT, 8'h00)});

      // Three wait states on PC 0, preceded by a spurious rvalid in IDLE.
      load_fill();
      mem[0] = mk(OP_ADD, 8'h11);
      apply_reset();
      wait_n = 3;
      force_rv = 1'b1; cyc(1); force_rv = 1'b0;
      check("idle_rvalid", 32'({req, valid, instr}), 32'd0);
      cyc(1);
      check("idle_stays", 32'({req, valid}), 32'd0);
      pulse_start();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("wait_cyc%0d", k), 32'({req, valid, addr}), {22'd0, 1'b1, 1'b0, 8'd0});
         cyc(1);
      end
      check("wait_exec", 32'({req, valid, instr}), {14'd0, 1'b0, 1'b1, mk(OP_ADD, 8'h11)});
      cyc(1);
      check("wait_next", 32'({req, valid, addr}), {22'd0, 1'b1, 1'b0, 8'd1});
      wait_n = 0;

      // BEQ at PC 5 with offset -3: INCREMENT -> 6, RELATIVE -> 2.
      for (int m = 0; m < 2; m++) begin
         load_fill();
         for (int i = 0; i < 5; i++) mem[i] = mk(OP_ADD, 8'h00);
         mem[5] = mk(OP_BEQ, 8'hFD);
         beq_mode = 2'(m);
         apply_reset();
         pulse_start();
         wait_exec_at(8'd5, $sformatf("beq_m%0d", m));
         cyc(1);
         check($sformatf("beq_m%0d_addr", m), 32'({req, addr}), {23'd0, 1'b1, exp_br[m]});
         check($sformatf("beq_m%0d_ret", m), 32'(retired), 32'd6);
      end

      // PC wrap: 0 -(-1)-> 0xFF -(+1)-> 0x00.
      load_fill();
      mem[0] = mk(OP_BEQ, 8'hFF); mem[255] = mk(OP_ADD, 8'h00);
      beq_mode = 2'd1;
      apply_reset();
      pulse_start();
      wait_exec_at(8'h00, "wrap_a0");
      cyc(1); check("wrap_neg", 32'(addr), 32'hFF);
      wait_exec_at(8'hFF, "wrap_aff");
      cyc(1); check("wrap_inc", 32'({req, addr}), {23'd0, 1'b1, 8'h00});

      // Relative +3 from 0xFE -> 0x01.
      load_fill();
      mem[0] = mk(OP_BEQ, 8'hFE); mem[254] = mk(OP_BEQ, 8'h03);
      apply_reset();
      pulse_start();
      wait_exec_at(8'h00, "rel_a0");
      cyc(1); check("rel_neg2", 32'(addr), 32'hFE);
      wait_exec_at(8'hFE, "rel_afe");
      cyc(1); check("rel_plus3", 32'({req, addr}), {23'd0, 1'b1, 8'h01});

      // Undefined opcode: HALTCOUNT + halt request, then start/rvalid ignored.
      load_fill();
      mem[0] = mk(OP_ADD, 8'h00); mem[1] = mk(OP_UNDEF, 8'h5A);
      apply_reset();
      pulse_start();
      wait_halted("undef");
      check("undef_state", {req, valid, pc, instr}, {14'd0, 8'd1, mk(OP_UNDEF, 8'h5A)});
      check("undef_ret", 32'(retired), 32'd1);
      start = 1'b1; force_rv = 1'b1;
      cyc(4);
      start = 1'b0; force_rv = 1'b0;
      check("halt_hold", {req, valid, halted, pc, instr}, {13'd0, 1'b1, 8'd1, mk(OP_UNDEF, 8'h5A)});
      check("halt_hold_ret", 32'(retired), 32'd1);

      // Halt request with INCREMENT, and reserved mode 3, both stop at PC 0.
      for (int s = 0; s < 2; s++) begin
         load_fill();
         mem[0] = mk(stop_ops[s], 8'h00);
         apply_reset();
         pulse_start();
         wait_halted($sformatf("stop%0d", s));
         check($sformatf("stop%0d_state", s), 32'({pc, retired}), 32'd0);
      end

      // Asynchronous reset mid-FETCH with rvalid in the same cycle.
      load_fill();
      mem[0] = mk(OP_ADD, 8'h00); mem[1] = mk(OP_ADD, 8'h77);
      wait_n = 2;
      apply_reset();
      pulse_start();
      wait_exec_at(8'h00, "arst");
      cyc(2);
      check("arst_pre", 32'({req, pc, retired[7:0]}), {15'd0, 1'b1, 8'd1, 8'd1});
      force_rv = 1'b1;
      rst_n = 1'b0;
      #1;
      check("arst_now", {req, valid, halted, pc, instr}, 32'd0);
      check("arst_now_ret", 32'(retired), 32'd0);
      cyc(1);
      rst_n = 1'b1; force_rv = 1'b0;
      cyc(3);
      check("arst_after", {req, valid, halted, pc, instr}, 32'd0);
      wait_n = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
